// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 2W/W restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_DZ  = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;

    localparam int W_DEF = 64;

    // Counter must be able to hold the terminal value W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(W_DEF + 1);

endpackage

// File: rtl/div_128b_seq_if.sv
// Valid/ready operand and result channels of the divider.
interface div_128b_seq_if #(
    parameter int W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in0;
    logic [W-1:0]     in1;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out0;
    logic [W-1:0]     out1;
    logic [1:0]       err;

    modport slave (
        input  in_valid, in0, in1, out_ready,
        output in_ready, out_valid, out0, out1, err
    );

    modport master (
        output in_valid, in0, in1, out_ready,
        input  in_ready, out_valid, out0, out1, err
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, subtract D if it fits.
module div_step #(
    parameter int W = 64
) (
    input  logic [W:0]   r_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] d_i,
    output logic [W:0]   r_o,
    output logic [W-1:0] q_o
);
    logic [W+1:0] r_sh;
    logic [W+1:0] diff;

    always_comb begin
        r_sh = {r_i, q_i[W-1]};
        diff = r_sh - {2'b00, d_i};
        // A clear sign bit means the trial subtraction did not borrow.
        if (!diff[W+1]) begin
            r_o = diff[W:0];
            q_o = {q_i[W-2:0], 1'b1};
        end else begin
            r_o = r_sh[W:0];
            q_o = {q_i[W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_128b_seq.sv
// Sequential unsigned divider, 2W-bit dividend by W-bit divisor, ITER quotient bits per clock.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// BUSY  | running restoring iterations, ITER per clock
// DONE  | result held on out0/out1/err with out_valid until consumed
module div_128b_seq
    import div_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int ITER = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    div_128b_seq_if.slave bus
);
    localparam int CW = cnt_width(W);

    state_t          state_q, state_d;
    logic [W:0]      r_q, r_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [W-1:0]    out0_q, out0_d;
    logic [W-1:0]    out1_q, out1_d;
    logic [1:0]      err_q, err_d;

    logic [W:0]      r_chain [ITER+1];
    logic [W-1:0]    q_chain [ITER+1];

    assign r_chain[0] = r_q;
    assign q_chain[0] = q_q;

    for (genvar g = 0; g < ITER; g++) begin : g_step
        div_step #(.W(W)) u_step (
            .r_i (r_chain[g]),
            .q_i (q_chain[g]),
            .d_i (d_q),
            .r_o (r_chain[g+1]),
            .q_o (q_chain[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        err_d   = err_q;
        cnt_nxt = cnt_q + CW'(ITER);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // High half >= divisor covers both a zero divisor and a quotient wider than W.
                    if (bus.in1 == '0) begin
                        err_d   = ERR_DZ;
                        out0_d  = '1;
                        out1_d  = bus.in0[W-1:0];
                        state_d = DONE;
                    end else if (bus.in0[2*W-1:W] >= bus.in1) begin
                        err_d   = ERR_OVF;
                        out0_d  = '1;
                        out1_d  = bus.in0[W-1:0];
                        state_d = DONE;
                    end else begin
                        r_d     = {1'b0, bus.in0[2*W-1:W]};
                        q_d     = bus.in0[W-1:0];
                        d_d     = bus.in1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                r_d   = r_chain[ITER];
                q_d   = q_chain[ITER];
                cnt_d = cnt_nxt;
                if (cnt_nxt == CW'(W)) begin
                    out0_d  = q_chain[ITER];
                    out1_d  = r_chain[ITER][W-1:0];
                    err_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_div_128b_seq.sv
// Scoreboard bench for div_128b_seq: directed vectors plus constructed q*d+r vectors.
module tb_div_128b_seq;
    import div_pkg::*;

    localparam int W     = 64;
    localparam int ITER  = 1;
    localparam int LAT_N = W / ITER + 1;
    localparam int LAT_E = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_128b_seq_if #(.W(W)) bus ();

    div_128b_seq #(.W(W), .ITER(ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   e;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   cyc       = 0;
    int   stall_cfg = 0;
    int   last_hs   = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [127:0] a, input logic [63:0] b,
                         input logic [63:0] q, input logic [63:0] r,
                         input logic [1:0] e, input int lat, output int acc);
        exp_t x;
        int   t;
        t = 0;
        acc = -1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in0      = a;
        bus.in1      = b;
        while (bus.in_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        x.q = q; x.r = r; x.e = e; x.lat = lat; x.acc = cyc;
        acc = cyc;
        exp_q.push_back(x);
        // Scramble the operands right after acceptance; the result must not depend on them.
        bus.in_valid = 1'b0;
        bus.in0      = ~a;
        bus.in1      = ~b;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: compares on the first out_valid cycle, then checks hold stability while stalled.
    logic [W-1:0] h_q, h_r;
    logic [1:0]   h_e;
    bit           prev_ov    = 1'b0;
    bit           chk_rdy    = 1'b0;
    int           stall_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov       = 1'b0;
            chk_rdy       = 1'b0;
            stall_left    = 0;
            bus.out_ready = 1'b1;
        end else begin
            if (chk_rdy) begin
                chk("post_hs_in_ready", bus.in_ready, 1);
                chk("post_hs_out_valid", bus.out_valid, 0);
                chk_rdy = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (!prev_ov) begin
                    h_q = bus.out0;
                    h_r = bus.out1;
                    h_e = bus.err;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        chk("quotient", bus.out0, exp_q[0].q);
                        chk("remainder", bus.out1, exp_q[0].r);
                        chk("err", bus.err, exp_q[0].e);
                        chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
                    end
                    stall_left = stall_cfg;
                end else begin
                    chk("hold_quotient", bus.out0, h_q);
                    chk("hold_remainder", bus.out1, h_r);
                    chk("hold_err", bus.err, h_e);
                    chk("in_ready_in_done", bus.in_ready, 0);
                    if (stall_left > 0) stall_left--;
                end
                bus.out_ready = (stall_left == 0);
                if (bus.out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    chk_rdy = 1'b1;
                    last_hs = cyc + 1;
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [63:0]  rd, rq, rr;
        logic [127:0] ra;

        bus.in_valid = 1'b0;
        bus.in0      = '0;
        bus.in1      = '0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out0", bus.out0, 0);
        chk("rst_out1", bus.out1, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;

        issue(128'd100, 64'd7, 64'd14, 64'd2, 2'b00, LAT_N, acc);
        issue(128'h1234, 64'd0, '1, 64'h1234, ERR_DZ, LAT_E, acc);
        issue(128'h1_0000_0000_0000_0000, 64'd1, '1, 64'd0, ERR_OVF, LAT_E, acc);
        issue({64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, LAT_N, acc);
        issue(128'd5, 64'd9, 64'd0, 64'd5, 2'b00, LAT_N, acc);
        issue({64'd6, 64'd0}, 64'd7, 64'hDB6D_B6DB_6DB6_DB6D, 64'd5, 2'b00, LAT_N, acc);
        issue({64'd7, 64'd3}, 64'd7, '1, 64'd3, ERR_OVF, LAT_E, acc);
        wait_idle();

        // Consumer stall, then back-to-back acceptance.
        stall_cfg = 10;
        issue(128'd1000, 64'd3, 64'd333, 64'd1, 2'b00, LAT_N, acc);
        issue(128'd200, 64'd10, 64'd20, 64'd0, 2'b00, LAT_N, acc);
        chk("b2b_accept_cycle", acc, last_hs + 1);
        wait_idle();
        stall_cfg = 0;
        issue(128'd77, 64'd0, '1, 64'd77, ERR_DZ, LAT_E, acc);
        issue(128'd81, 64'd9, 64'd9, 64'd0, 2'b00, LAT_N, acc);
        chk("b2b_accept_err", acc, last_hs + 1);
        wait_idle();

        // Reset in the middle of an operation.
        issue(128'd100, 64'd7, 64'd14, 64'd2, 2'b00, LAT_N, acc);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_out_valid", bus.out_valid, 0);
            chk("midrst_in_ready", bus.in_ready, 1);
        end
        rst_n = 1'b1;
        issue(128'd100, 64'd7, 64'd14, 64'd2, 2'b00, LAT_N, acc);
        wait_idle();

        // Constructed vectors: dividend = q*d + r with r < d, so the quotient fits W bits.
        for (int i = 0; i < 24; i++) begin
            rd = {$urandom, $urandom};
            if (i % 4 == 0) rd = 64'($urandom_range(1, 1000));
            if (rd == 0) rd = 64'd1;
            rq = {$urandom, $urandom};
            rr = {$urandom, $urandom} % rd;
            ra = 128'(rq) * 128'(rd) + 128'(rr);
            issue(ra, rd, rq, rr, 2'b00, LAT_N, acc);
        end
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
